// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encodings and the
// default bit period (50 MHz / 115200 baud).
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_POP   = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_START = 3'd3;
    localparam logic [STATE_W-1:0] ST_DATA  = 3'd4;
    localparam logic [STATE_W-1:0] ST_STOP  = 3'd5;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high on the last clock of every CLKS_PER_BIT-clock
// bit. restart holds the count at zero so the next bit begins on a clean boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Reloading on tick (not free-running modulo) keeps every bit exactly one period.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an upstream FIFO one frame at a time:
// pop, wait one clock for read data, then send start / LSB-first data / stop.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output logic [STATE_W-1:0]    dbg_state
);

    localparam int               BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic [STATE_W-1:0]    state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  baud_tick;
    logic                  baud_restart;
    logic                  can_start;

    // FIFO handshake: fifo_read is a one-clock pop strobe issued only when the FIFO
    // reported non-empty; the popped word is expected on fifo_dout one clock later.
    assign can_start    = enable && !fifo_empty;
    assign baud_restart = (state == ST_IDLE) || (state == ST_POP) || (state == ST_WAIT);
    assign fifo_read    = (state == ST_POP);
    assign busy         = (state != ST_IDLE);
    assign dbg_state    = state;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(baud_restart),
        .tick   (baud_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_start) state <= ST_POP;
                end
                ST_POP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_START;
                    shreg <= fifo_dout;
                    tx    <= 1'b0;
                end
                ST_START: begin
                    if (baud_tick) begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // Chain straight into the next fetch so frames are only 2 clocks apart.
                    if (baud_tick) state <= can_start ? ST_POP : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clocks per UART bit (50 MHz / 115200); SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, bits per frame; SHALL match the upstream FIFO data width.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  drain permission; high allows new frames to start.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_dout  input  DATA_WIDTH  upstream FIFO read data.
REQ-008 fifo_read  output  1  one-clock pop strobe to the upstream FIFO.
REQ-009 tx  output  1  serial line, idle high, registered.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 States SHALL be IDLE, POP, WAIT, START, DATA, STOP.
REQ-012 IDLE -> POP when enable=1 and fifo_empty=0; otherwise stay in IDLE.
REQ-013 In POP, fifo_read=1 for exactly one clock; fifo_read=0 in all other states.
REQ-014 POP -> WAIT unconditionally; WAIT lasts one clock.
REQ-015 On the WAIT -> START edge, the shift register SHALL load fifo_dout; this is the only fifo_dout sample point.
REQ-016 START: tx=0 for CLKS_PER_BIT clocks.
REQ-017 DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT clocks.
REQ-018 STOP: tx=1 for CLKS_PER_BIT clocks.
REQ-019 At STOP end: -> POP if enable=1 and fifo_empty=0, else -> IDLE. Back-to-back frames are separated only by the 2-clock POP/WAIT fetch, with tx=1 during it.
REQ-020 tx=1 in IDLE, POP, WAIT and STOP.
REQ-021 Frame length from START entry to STOP exit SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT clocks.
REQ-022 Baud counter width SHALL be $clog2(CLKS_PER_BIT); the counter reloads at every bit boundary and does not drift.
REQ-023 Bit counter width SHALL be $clog2(DATA_WIDTH+1).
REQ-024 enable falling mid-frame (POP through STOP) SHALL NOT abort the frame; the frame completes and no further pop is issued.
REQ-025 fifo_read SHALL never assert while fifo_empty=1 is sampled in IDLE or at STOP end.
REQ-026 fifo_empty and enable changes during WAIT, START, DATA and STOP SHALL be ignored.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, tx=1, busy=0, fifo_read=0, and counters and shift register cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next edge, with no partial stop bit and no pop.
REQ-029 After rst_n rises, the first fifo_read SHALL occur no earlier than the first clock edge at which rst_n=1 is sampled.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state encodings and the default CLKS_PER_BIT constant.
REQ-031 A sub-module, uart_baud_tick (CLKS_PER_BIT counter with restart input and one-clock tick output), SHALL be used. All other logic stays in fifo_uart_tx.
REQ-032 The block SHALL connect directly to fifo: fifo_read->read, fifo.data_out->fifo_dout, fifo.empty->fifo_empty.

Verification (bench: fifo DEPTH=4, DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-033 Reset: hold rst_n=0 for 3 clocks -> tx=1, busy=0, fifo_read=0, no pop with enable=1 and FIFO empty.
REQ-034 Single byte: write 0xAA, enable=1 -> one fifo_read pulse; after WAIT, tx shows start 0, then 0,1,0,1,0,1,0,1, then stop 1, each 4 clocks (40 clocks); FIFO empty; busy falls.
REQ-035 Burst: fill C0..C3 (FIFO full), enable=1 -> exactly 4 fifo_read pulses, frames decode C0,C1,C2,C3 in order, 2-clock gap between frames, busy high throughout.
REQ-036 Gating: FIFO holds 0x55 with enable=0 -> no fifo_read and tx=1 for 100 clocks. Then enable=1 and drop enable during DATA -> 0x55 frame completes and no second pop.
REQ-037 Reset mid-frame: pull rst_n=0 during DATA bit 3 -> tx=1 and busy=0 after the next edge; remaining FIFO contents untouched until rst_n=1.
REQ-038 Simultaneous write/drain: write 0xD0 while a frame is in STOP -> STOP -> POP directly; next frame decodes 0xD0.
